// File: rtl/vga_pkg.sv
// Shared FSM encoding, timing presets and total helpers
// for the VGA raster timing generator.
package vga_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      int h_sync;
      int h_back;
      int h_active;
      int h_front;
      int v_sync;
      int v_back;
      int v_active;
      int v_front;
   } vga_timing_t;

   localparam vga_timing_t VGA_640x480_60 = '{
      h_sync: 96, h_back: 48, h_active: 640, h_front: 16,
      v_sync: 2, v_back: 33, v_active: 480, v_front: 10
   };

   localparam vga_timing_t SVGA_800x600_60 = '{
      h_sync: 128, h_back: 88, h_active: 800, h_front: 40,
      v_sync: 4, v_back: 23, v_active: 600, v_front: 1
   };

   localparam vga_timing_t XGA_1024x768_60 = '{
      h_sync: 136, h_back: 160, h_active: 1024, h_front: 24,
      v_sync: 6, v_back: 29, v_active: 768, v_front: 3
   };

   function automatic int h_total(int sync, int back,
                                  int active, int front);
      return sync + back + active + front;
   endfunction

   function automatic int v_total(int sync, int back,
                                  int active, int front);
      return sync + back + active + front;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value,
// used to align raw sync/de flags with the pixel source.
module vga_delay_line #(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with early pixel
// requests, frame-boundary start/stop and frame status.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int    H_SYNC   = VGA_640x480_60.h_sync,
   parameter int    H_BACK   = VGA_640x480_60.h_back,
   parameter int    H_ACTIVE = VGA_640x480_60.h_active,
   parameter int    H_FRONT  = VGA_640x480_60.h_front,
   parameter int    V_SYNC   = VGA_640x480_60.v_sync,
   parameter int    V_BACK   = VGA_640x480_60.v_back,
   parameter int    V_ACTIVE = VGA_640x480_60.v_active,
   parameter int    V_FRONT  = VGA_640x480_60.v_front,
   parameter bit    HS_POL   = 1'b0,
   parameter bit    VS_POL   = 1'b0,
   parameter int    RGB_W    = 16,
   parameter int    PIX_LEAD = 1,
   parameter int    FCNT_W   = 8,
   localparam int   XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
   localparam int   YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
   input  logic              vga_clk,
   input  logic              sys_rst,
   input  logic              run,
   input  logic [RGB_W-1:0]  pix_data,
   output logic              pix_req,
   output logic [XW-1:0]     pix_x,
   output logic [YW-1:0]     pix_y,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [RGB_W-1:0]  rgb,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
   localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
   localparam int HCW = $clog2(H_TOTAL);
   localparam int VCW = $clog2(V_TOTAL);

   localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
   localparam logic [HCW-1:0] H_SE   = HCW'(H_SYNC);
   localparam logic [HCW-1:0] H_AB   = HCW'(H_SYNC + H_BACK);
   localparam logic [HCW-1:0] H_AE   = HCW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
   localparam logic [VCW-1:0] V_SE   = VCW'(V_SYNC);
   localparam logic [VCW-1:0] V_AB   = VCW'(V_SYNC + V_BACK);
   localparam logic [VCW-1:0] V_AE   = VCW'(V_SYNC + V_BACK + V_ACTIVE);

   localparam logic [3:0] PIPE_IDLE = {1'b0, 1'b0, ~VS_POL, ~HS_POL};

   if (H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 || H_FRONT < 1 ||
       V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1)
   begin : g_bad_timing
      $error("vga_timing_gen: timing parameters must be >= 1");
   end

   if (PIX_LEAD < 0 || PIX_LEAD > 15) begin : g_bad_lead
      $error("vga_timing_gen: PIX_LEAD must be 0..15");
   end

   logic [1:0]     state;
   logic [HCW-1:0] h_cnt;
   logic [VCW-1:0] v_cnt;
   logic           h_end, v_end, f_end;
   logic           active, h_act, v_act;
   logic [3:0]     raw, dly;

   assign h_end = h_cnt == H_LAST;
   assign v_end = v_cnt == V_LAST;
   assign f_end = h_end && v_end;

   // A stop request only takes effect at the last pixel of a frame.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         state <= ST_IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE:  if (run) state <= ST_RUN;
            ST_RUN:   if (!run) state <= f_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
               if (run)        state <= ST_RUN;
               else if (f_end) state <= ST_IDLE;
            end
            default:  state <= ST_IDLE;
         endcase
         if (state != ST_IDLE) begin
            if (h_end) begin
               h_cnt <= '0;
               v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   assign active  = state != ST_IDLE;
   assign h_act   = (h_cnt >= H_AB) && (h_cnt < H_AE);
   assign v_act   = (v_cnt >= V_AB) && (v_cnt < V_AE);
   assign pix_req = active && h_act && v_act;
   assign pix_x   = pix_req ? XW'(h_cnt - H_AB) : '0;
   assign pix_y   = pix_req ? YW'(v_cnt - V_AB) : '0;

   assign raw[0] = (active && h_cnt < H_SE) ? HS_POL : ~HS_POL;
   assign raw[1] = (active && v_cnt < V_SE) ? VS_POL : ~VS_POL;
   assign raw[2] = pix_req;
   assign raw[3] = active && h_cnt == '0 && v_cnt == '0;

   if (PIX_LEAD == 0) begin : g_no_delay
      assign dly = raw;
   end else begin : g_delay
      vga_delay_line #(
         .DEPTH   (PIX_LEAD),
         .WIDTH   (4),
         .RST_VAL (PIPE_IDLE)
      ) u_dly (
         .clk  (vga_clk),
         .rst  (sys_rst),
         .din  (raw),
         .dout (dly)
      );
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         hsync       <= dly[0];
         vsync       <= dly[1];
         de          <= dly[2];
         rgb         <= dly[2] ? pix_data : '0;
         frame_start <= dly[3];
         if (dly[3]) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small raster, default
// 640x480, and inverted-polarity zero-lead configuration.
module tb_vga_timing_gen;

   logic vga_clk;
   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   int tests_run;
   int tests_failed;

   // small config, PIX_LEAD=2
   logic        s_rst, s_run, s_req, s_hs, s_vs, s_de, s_fs;
   logic [15:0] s_pix, s_ps1, s_rgb;
   logic [2:0]  s_x;
   logic [1:0]  s_y;
   logic [7:0]  s_cnt;

   // default 640x480, PIX_LEAD=1
   logic        v_rst, v_run, v_req, v_hs, v_vs, v_de, v_fs;
   logic [15:0] v_pix, v_rgb;
   logic [9:0]  v_x;
   logic [8:0]  v_y;
   logic [7:0]  v_cnt;

   // small config, inverted polarity, PIX_LEAD=0, FCNT_W=2
   logic        i_rst, i_run, i_req, i_hs, i_vs, i_de, i_fs;
   logic [15:0] i_pix, i_rgb;
   logic [2:0]  i_x;
   logic [1:0]  i_y;
   logic [1:0]  i_cnt;

   always @(posedge vga_clk) begin
      s_ps1 <= s_req ? (16'hA000 | {11'd0, s_y, s_x}) : 16'h0000;
      s_pix <= s_ps1;
      v_pix <= v_req ? {v_y[4:0], 1'b0, v_x} : 16'h0000;
   end
   assign i_pix = i_req ? (16'hB000 | {11'd0, i_y, i_x}) : 16'h0000;

   vga_timing_gen #(
      .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
      .PIX_LEAD(2)
   ) u_small (
      .vga_clk(vga_clk), .sys_rst(s_rst), .run(s_run),
      .pix_data(s_pix), .pix_req(s_req), .pix_x(s_x), .pix_y(s_y),
      .hsync(s_hs), .vsync(s_vs), .de(s_de), .rgb(s_rgb),
      .frame_start(s_fs), .frame_cnt(s_cnt)
   );

   vga_timing_gen u_vga (
      .vga_clk(vga_clk), .sys_rst(v_rst), .run(v_run),
      .pix_data(v_pix), .pix_req(v_req), .pix_x(v_x), .pix_y(v_y),
      .hsync(v_hs), .vsync(v_vs), .de(v_de), .rgb(v_rgb),
      .frame_start(v_fs), .frame_cnt(v_cnt)
   );

   vga_timing_gen #(
      .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LEAD(0), .FCNT_W(2)
   ) u_inv (
      .vga_clk(vga_clk), .sys_rst(i_rst), .run(i_run),
      .pix_data(i_pix), .pix_req(i_req), .pix_x(i_x), .pix_y(i_y),
      .hsync(i_hs), .vsync(i_vs), .de(i_de), .rgb(i_rgb),
      .frame_start(i_fs), .frame_cnt(i_cnt)
   );

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic test_reset();
      s_rst = 1'b1; s_run = 1'b0;
      v_rst = 1'b1; v_run = 1'b0;
      i_rst = 1'b1; i_run = 1'b0;
      repeat (3) tick();
      tests_run++;
      if (s_hs !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_s_hsync: got %b expected 1", s_hs);
      end
      tests_run++;
      if (s_vs !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_s_vsync: got %b expected 1", s_vs);
      end
      tests_run++;
      if (s_de !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_s_de: got %b expected 0", s_de);
      end
      tests_run++;
      if (s_rgb !== 16'h0) begin
         tests_failed++;
         $display("FAIL rst_s_rgb: got %h expected 0", s_rgb);
      end
      tests_run++;
      if (s_fs !== 1'b0 || s_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL rst_s_frame: got fs=%b cnt=%0d expected 0/0",
                  s_fs, s_cnt);
      end
      tests_run++;
      if (i_hs !== 1'b0 || i_vs !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_i_sync: got hs=%b vs=%b expected 0/0",
                  i_hs, i_vs);
      end
      tests_run++;
      if (v_hs !== 1'b1 || v_vs !== 1'b1 || v_de !== 1'b0 ||
          v_fs !== 1'b0 || v_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL rst_v_outs: got hs=%b vs=%b de=%b fs=%b cnt=%0d",
                  v_hs, v_vs, v_de, v_fs, v_cnt);
      end
   endtask

   task automatic test_small_frames();
      int k, hs_low, vs_low, de_hi, fs_n, first_de, rgb_bad, zero_bad;
      int dei;
      logic hs0, hs4;
      logic [15:0] exp;
      s_rst = 1'b0;
      s_run = 1'b1;
      k = 0;
      while (k < 20) begin
         tick();
         k++;
         if (s_fs) break;
      end
      tests_run++;
      if (k != 4) begin
         tests_failed++;
         $display("FAIL small_first_fs_latency: got %0d expected 4", k);
      end
      hs_low = 0; vs_low = 0; de_hi = 0; fs_n = 0;
      first_de = -1; rgb_bad = 0; zero_bad = 0; dei = 0;
      hs0 = 1'b1; hs4 = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (i > 0) tick();
         if (i == 0) hs0 = s_hs;
         if (i == 4) hs4 = s_hs;
         if (!s_hs) hs_low++;
         if (!s_vs) vs_low++;
         if (s_fs) fs_n++;
         if (s_de) begin
            if (first_de < 0) first_de = i;
            exp = 16'hA000 | 16'((((dei % 32) / 8) << 3) | (dei % 8));
            if (s_rgb !== exp) rgb_bad++;
            de_hi++;
            dei++;
         end else if (s_rgb !== 16'h0) begin
            zero_bad++;
         end
      end
      tests_run++;
      if (hs0 !== 1'b0 || hs4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL small_hs_phase: got %b/%b expected 0/1", hs0, hs4);
      end
      tests_run++;
      if (hs_low != 64) begin
         tests_failed++;
         $display("FAIL small_hs_low: got %0d expected 64", hs_low);
      end
      tests_run++;
      if (vs_low != 64) begin
         tests_failed++;
         $display("FAIL small_vs_low: got %0d expected 64", vs_low);
      end
      tests_run++;
      if (de_hi != 64) begin
         tests_failed++;
         $display("FAIL small_de_high: got %0d expected 64", de_hi);
      end
      tests_run++;
      if (first_de != 54) begin
         tests_failed++;
         $display("FAIL small_first_de: got %0d expected 54", first_de);
      end
      tests_run++;
      if (fs_n != 2 || s_cnt !== 8'd2) begin
         tests_failed++;
         $display("FAIL small_frames: got fs=%0d cnt=%0d expected 2/2",
                  fs_n, s_cnt);
      end
      tests_run++;
      if (rgb_bad != 0 || zero_bad != 0) begin
         tests_failed++;
         $display("FAIL small_rgb: got %0d bad pixels %0d bad blanks expected 0",
                  rgb_bad, zero_bad);
      end
   endtask

   task automatic test_drain();
      int k, de_hi, fs_n, hs_low, vs_low;
      s_rst = 1'b1; s_run = 1'b0;
      tick();
      s_rst = 1'b0; s_run = 1'b1;
      k = 0;
      while (k < 20) begin tick(); k++; if (s_fs) break; end
      k = 0;
      while (k < 200) begin tick(); k++; if (s_fs) break; end
      tests_run++;
      if (k != 128 || s_cnt !== 8'd2) begin
         tests_failed++;
         $display("FAIL drain_second_fs: got gap=%0d cnt=%0d expected 128/2",
                  k, s_cnt);
      end
      de_hi = 0; fs_n = 0; hs_low = 0; vs_low = 0;
      for (int i = 0; i < 200; i++) begin
         if (i > 0) tick();
         if (i > 0 && s_fs) fs_n++;
         if (s_de) de_hi++;
         if (!s_hs) hs_low++;
         if (!s_vs) vs_low++;
         if (i == 48) s_run = 1'b0;
      end
      tests_run++;
      if (de_hi != 32 || hs_low != 32 || vs_low != 32) begin
         tests_failed++;
         $display("FAIL drain_complete: got de=%0d hs=%0d vs=%0d expected 32 each",
                  de_hi, hs_low, vs_low);
      end
      tests_run++;
      if (fs_n != 0 || s_cnt !== 8'd2) begin
         tests_failed++;
         $display("FAIL drain_no_third: got fs=%0d cnt=%0d expected 0/2",
                  fs_n, s_cnt);
      end
      tests_run++;
      if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_de !== 1'b0 ||
          s_rgb !== 16'h0) begin
         tests_failed++;
         $display("FAIL drain_idle: got hs=%b vs=%b de=%b rgb=%h expected 1/1/0/0",
                  s_hs, s_vs, s_de, s_rgb);
      end
   endtask

   task automatic test_back_to_back();
      int k, fs1, fs2, de_hi;
      s_rst = 1'b1; s_run = 1'b0;
      tick();
      s_rst = 1'b0; s_run = 1'b1;
      k = 0;
      while (k < 20) begin tick(); k++; if (s_fs) break; end
      fs1 = -1; fs2 = -1; de_hi = 0;
      for (int i = 0; i < 300; i++) begin
         if (i > 0) tick();
         if (i > 0 && s_fs) begin
            if (fs1 < 0) fs1 = i;
            else if (fs2 < 0) fs2 = i;
         end
         if (i < 256 && s_de) de_hi++;
         if (i == 20) s_run = 1'b0;
         if (i == 30) s_run = 1'b1;
      end
      tests_run++;
      if (fs1 != 128 || fs2 != 256) begin
         tests_failed++;
         $display("FAIL toggle_period: got %0d/%0d expected 128/256", fs1, fs2);
      end
      tests_run++;
      if (de_hi != 64) begin
         tests_failed++;
         $display("FAIL toggle_de: got %0d expected 64", de_hi);
      end
   endtask

   task automatic test_reset_mid_line();
      int k;
      k = 0;
      while (k < 200) begin tick(); k++; if (s_de) break; end
      tick();
      tick();
      tests_run++;
      if (s_de !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_in_line: got de=%b expected 1", s_de);
      end
      s_rst = 1'b1;
      tick();
      tests_run++;
      if (s_de !== 1'b0 || s_rgb !== 16'h0) begin
         tests_failed++;
         $display("FAIL midrst_de_rgb: got de=%b rgb=%h expected 0/0",
                  s_de, s_rgb);
      end
      tests_run++;
      if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_fs !== 1'b0 ||
          s_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL midrst_sync_cnt: got hs=%b vs=%b fs=%b cnt=%0d expected 1/1/0/0",
                  s_hs, s_vs, s_fs, s_cnt);
      end
      s_rst = 1'b0;
      k = 0;
      while (k < 20) begin tick(); k++; if (s_fs) break; end
      tests_run++;
      if (k != 4 || s_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL midrst_restart: got lat=%0d cnt=%0d expected 4/1",
                  k, s_cnt);
      end
   endtask

   task automatic test_default_640();
      int k;
      v_rst = 1'b0;
      v_run = 1'b1;
      k = 0;
      while (k < 30000) begin tick(); k++; if (v_de) break; end
      tests_run++;
      if (k != 35 * 800 + 144 + 2 + 1) begin
         tests_failed++;
         $display("FAIL vga_first_de: got %0d expected %0d",
                  k, 35 * 800 + 144 + 2 + 1);
      end
      tests_run++;
      if (v_rgb !== 16'h0000 || v_hs !== 1'b1 || v_vs !== 1'b1) begin
         tests_failed++;
         $display("FAIL vga_first_pix: got rgb=%h hs=%b vs=%b expected 0000/1/1",
                  v_rgb, v_hs, v_vs);
      end
      tick();
      tests_run++;
      if (v_rgb !== 16'h0001 || v_de !== 1'b1) begin
         tests_failed++;
         $display("FAIL vga_x1: got rgb=%h de=%b expected 0001/1", v_rgb, v_de);
      end
      repeat (638) tick();
      tests_run++;
      if (v_rgb !== 16'h027F || v_de !== 1'b1) begin
         tests_failed++;
         $display("FAIL vga_x639: got rgb=%h de=%b expected 027f/1",
                  v_rgb, v_de);
      end
      tick();
      tests_run++;
      if (v_rgb !== 16'h0000 || v_de !== 1'b0) begin
         tests_failed++;
         $display("FAIL vga_line_end: got rgb=%h de=%b expected 0000/0",
                  v_rgb, v_de);
      end
      v_rst = 1'b1;
      v_run = 1'b0;
      tick();
   endtask

   task automatic test_inverted();
      int k, n, hs_hi, vs_hi, de_hi, rgb_bad, dei;
      logic [15:0] exp;
      i_rst = 1'b0;
      i_run = 1'b1;
      k = 0;
      while (k < 20) begin tick(); k++; if (i_fs) break; end
      tests_run++;
      if (k != 2) begin
         tests_failed++;
         $display("FAIL inv_latency: got %0d expected 2", k);
      end
      tests_run++;
      if (i_hs !== 1'b1 || i_vs !== 1'b1 || i_cnt !== 2'd1) begin
         tests_failed++;
         $display("FAIL inv_first_fs: got hs=%b vs=%b cnt=%0d expected 1/1/1",
                  i_hs, i_vs, i_cnt);
      end
      n = 1; hs_hi = 0; vs_hi = 0; de_hi = 0; rgb_bad = 0; dei = 0;
      for (int i = 0; i < 640; i++) begin
         if (i > 0) tick();
         if (i > 0 && i_fs) begin
            n++;
            tests_run++;
            if (i_cnt !== 2'(n)) begin
               tests_failed++;
               $display("FAIL inv_fcnt: fs %0d got %0d expected %0d",
                        n, i_cnt, n % 4);
            end
         end
         if (i < 128) begin
            if (i_hs) hs_hi++;
            if (i_vs) vs_hi++;
            if (i_de) begin
               exp = 16'hB000 | 16'((((dei % 32) / 8) << 3) | (dei % 8));
               if (i_rgb !== exp) rgb_bad++;
               de_hi++;
               dei++;
            end
         end
      end
      tests_run++;
      if (hs_hi != 32 || vs_hi != 32 || de_hi != 32) begin
         tests_failed++;
         $display("FAIL inv_counts: got hs=%0d vs=%0d de=%0d expected 32 each",
                  hs_hi, vs_hi, de_hi);
      end
      tests_run++;
      if (rgb_bad != 0) begin
         tests_failed++;
         $display("FAIL inv_rgb: got %0d bad pixels expected 0", rgb_bad);
      end
      tests_run++;
      if (n != 5) begin
         tests_failed++;
         $display("FAIL inv_frames: got %0d expected 5", n);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_small_frames();
      test_drain();
      test_back_to_back();
      test_reset_mid_line();
      test_default_640();
      test_inverted();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
